// File: rtl/hlr_div_pkg.sv
// Shared types and constants for the sequential signed divider hlr_div_seq.
// Covers the FSM state enum, operand/result widths, saturation limits and magnitude helpers.
package hlr_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DVD_W       = 16;
    localparam int DVS_W       = 8;
    localparam int Q_W         = 8;
    localparam int EXACT_STEPS = 16;

    localparam logic [Q_W-1:0] Q_MAX = 8'h7F;
    localparam logic [Q_W-1:0] Q_MIN = 8'h80;

    // Unsigned magnitude; the most negative value maps to 2^(W-1), which still fits.
    function automatic logic [DVD_W-1:0] abs_dvd(input logic [DVD_W-1:0] v);
        return v[DVD_W-1] ? (~v + 16'd1) : v;
    endfunction

    function automatic logic [DVS_W-1:0] abs_dvs(input logic [DVS_W-1:0] v);
        return v[DVS_W-1] ? (~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/hlr_div_seq_if.sv
// Operand/result bundle for hlr_div_seq: an input handshake and an output handshake.
interface hlr_div_seq_if;
    import hlr_div_pkg::*;

    // A transfer happens on a rising edge where valid and ready are both high;
    // once raised, valid and its payload hold until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [Q_W-1:0]   quot;
    logic [Q_W-1:0]   rem;
    logic             ovf;
    logic             dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, ovf, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, ovf, dz
    );

endinterface

// File: rtl/hlr_div_step.sv
// One restoring division iteration on magnitudes: shift in a dividend bit, trial-subtract.
module hlr_div_step
    import hlr_div_pkg::*;
(
    input  logic [DVS_W-1:0] prem_i,
    input  logic             bit_i,
    input  logic [DVS_W-1:0] dvs_i,
    output logic [DVS_W-1:0] prem_o,
    output logic             qbit_o
);

    logic [DVS_W:0] shifted;

    // The partial remainder stays below |divisor| <= 128, so 8 bits always hold it.
    assign shifted = {prem_i, bit_i};
    assign qbit_o  = (shifted >= {1'b0, dvs_i});
    assign prem_o  = qbit_o ? DVS_W'(shifted - {1'b0, dvs_i}) : shifted[DVS_W-1:0];

endmodule

// File: rtl/hlr_div_seq.sv
// Sequential signed divider, 16b / 8b -> saturated 8b quotient and 8b remainder.
// Define HLR_DIV_APPROX_EN to skip the last APPROX_BITS quotient iterations (remainder forced to 0).
module hlr_div_seq
    import hlr_div_pkg::*;
#(
    parameter int unsigned APPROX_BITS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    hlr_div_seq_if.slave   bus,
    output state_e         state_o
);

`ifdef HLR_DIV_APPROX_EN
    localparam int unsigned SKIP = APPROX_BITS;
`else
    localparam int unsigned SKIP = 0;
`endif
    localparam int unsigned STEPS     = EXACT_STEPS - SKIP;
    localparam logic [3:0]  LAST_STEP = 4'(STEPS - 1);

    if (APPROX_BITS < 1 || APPROX_BITS > 8) begin : g_bad_approx_bits
        $error("hlr_div_seq: APPROX_BITS must be in 1..8");
    end

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             zero_q, zero_d;
    logic [DVS_W-1:0] prem_q, prem_d;
    logic [DVD_W-1:0] qmag_q, qmag_d;
    logic [Q_W-1:0]   quot_q, quot_d;
    logic [Q_W-1:0]   rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [DVS_W-1:0] step_prem;
    logic             step_qbit;
    logic             dvd_bit;
    logic [DVD_W-1:0] qfin;

    // The dividend magnitude is never shifted, so its low byte is still there for the divide-by-zero remainder.
    assign dvd_bit = dvd_q[4'd15 - cnt_q];
    assign qfin    = qmag_q << SKIP;

    hlr_div_step u_step (
        .prem_i (prem_q),
        .bit_i  (dvd_bit),
        .dvs_i  (dvs_q),
        .prem_o (step_prem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        zero_d    = zero_q;
        prem_d    = prem_q;
        qmag_d    = qmag_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvd_d     = abs_dvd(bus.dividend);
                    dvs_d     = abs_dvs(bus.divisor);
                    dvd_neg_d = bus.dividend[DVD_W-1];
                    dvs_neg_d = bus.divisor[DVS_W-1];
                    zero_d    = (bus.divisor == '0);
                    cnt_d     = '0;
                    prem_d    = '0;
                    qmag_d    = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                prem_d = step_prem;
                qmag_d = {qmag_q[DVD_W-2:0], step_qbit};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_STEP) state_d = FIX;
            end
            FIX: begin
                ovf_d = 1'b0;
                dz_d  = zero_q;
                if (zero_q) begin
                    quot_d = dvd_neg_q ? Q_MIN : Q_MAX;
                    rem_d  = dvd_neg_q ? (~dvd_q[7:0] + 8'd1) : dvd_q[7:0];
                    ovf_d  = 1'b1;
                end else begin
                    if (dvd_neg_q ^ dvs_neg_q) begin
                        // -128 is representable, so only magnitudes above 128 saturate.
                        if (qfin > 16'd128) begin
                            quot_d = Q_MIN;
                            ovf_d  = 1'b1;
                        end else begin
                            quot_d = ~qfin[Q_W-1:0] + 8'd1;
                        end
                    end else if (qfin > 16'd127) begin
                        quot_d = Q_MAX;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = qfin[Q_W-1:0];
                    end
`ifdef HLR_DIV_APPROX_EN
                    rem_d = '0;
`else
                    rem_d = dvd_neg_q ? (~prem_q + 8'd1) : prem_q;
`endif
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            prem_q    <= '0;
            qmag_q    <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            zero_q    <= zero_d;
            prem_q    <= prem_d;
            qmag_q    <= qmag_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_hlr_div_seq.sv
// Directed bench for hlr_div_seq in its exact (default) build.
module tb_hlr_div_seq;
  import hlr_div_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  state_e dbg_state;
  int     n_vec = 0;
  int     n_err = 0;
  logic [17:0] exp_q[$];

  hlr_div_seq_if bus();

  hlr_div_seq #(.APPROX_BITS(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic send(input string tag, input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    check_eq({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom_range(0, 65535));
    bus.divisor  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_result(input string tag);
    int cyc = 0;
    logic [17:0] e;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, " latency"}, 32'(cyc), 32'd17);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, " quot"}, 32'(bus.quot), 32'(e[17:10]));
      check_eq({tag, " rem"},  32'(bus.rem),  32'(e[9:2]));
      check_eq({tag, " ovf"},  32'(bus.ovf),  32'(e[1]));
      check_eq({tag, " dz"},   32'(bus.dz),   32'(e[0]));
    end
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, " in_ready back"},  32'(bus.in_ready),  32'd1);
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic eo, input logic ez);
    exp_q.push_back({eq, er, eo, ez});
    send(tag, a, b);
    wait_result(tag);
    take(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("rst out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst quot",      32'(bus.quot),      32'd0);
    check_eq("rst rem",       32'(bus.rem),       32'd0);
    check_eq("rst ovf",       32'(bus.ovf),       32'd0);
    check_eq("rst dz",        32'(bus.dz),        32'd0);
    check_eq("rst state",     32'(dbg_state),     32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // hand-computed vectors: dividend, divisor -> quot, rem, ovf, dz
    run_div("42/6",        16'd42,     8'd6,     8'h07, 8'h00, 1'b0, 1'b0);
    run_div("-100/7",      -16'sd100,  8'd7,     8'hF2, 8'hFE, 1'b0, 1'b0);
    run_div("100/-7",      16'd100,    -8'sd7,   8'hF2, 8'h02, 1'b0, 1'b0);
    run_div("1000/-3",     16'd1000,   -8'sd3,   8'h80, 8'h01, 1'b1, 1'b0);
    run_div("-16384/-128", -16'sd16384, 8'h80,   8'h7F, 8'h00, 1'b1, 1'b0);
    run_div("-5/0",        -16'sd5,    8'd0,     8'h80, 8'hFB, 1'b1, 1'b1);
    run_div("7/0",         16'd7,      8'd0,     8'h7F, 8'h07, 1'b1, 1'b1);
    run_div("127/1",       16'd127,    8'd1,     8'h7F, 8'h00, 1'b0, 1'b0);
    run_div("128/1",       16'd128,    8'd1,     8'h7F, 8'h00, 1'b1, 1'b0);
    run_div("-128/1",      -16'sd128,  8'd1,     8'h80, 8'h00, 1'b0, 1'b0);
    run_div("-129/1",      -16'sd129,  8'd1,     8'h80, 8'h00, 1'b1, 1'b0);
    run_div("-32768/-1",   16'h8000,   8'hFF,    8'h7F, 8'h00, 1'b1, 1'b0);
    run_div("-7/2",        -16'sd7,    8'd2,     8'hFD, 8'hFF, 1'b0, 1'b0);
    run_div("0/5",         16'd0,      8'd5,     8'h00, 8'h00, 1'b0, 1'b0);
    run_div("32767/127",   16'd32767,  8'd127,   8'h7F, 8'h01, 1'b1, 1'b0);

    // backpressure: result held, new requests ignored
    exp_q.push_back({8'h07, 8'h00, 1'b0, 1'b0});
    send("bp", 16'd42, 8'd6);
    wait_result("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 16'd9;
      bus.divisor  = 8'd1;
      @(posedge clk);
      #1;
      check_eq("bp hold quot",     32'(bus.quot),      32'h07);
      check_eq("bp hold rem",      32'(bus.rem),       32'h00);
      check_eq("bp hold out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp hold in_ready", 32'(bus.in_ready),  32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    take("bp");
    @(posedge clk);
    #1;
    check_eq("bp no new op", 32'(dbg_state), 32'(IDLE));

    // reset in the middle of CALC aborts the operation
    send("rstmid", 16'd42, 8'd6);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rstmid in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("rstmid state",     32'(dbg_state),     32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_div("42/6 after rst", 16'd42, 8'd6, 8'h07, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
